product_rescaler: RTL and testbench



---
 rtl/product_rescaler_pkg.sv | 16 +
 rtl/product_rescaler_sat_counter.sv | 34 +++
 rtl/product_rescaler.sv | 84 ++++++++
 tb/tb_product_rescaler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/product_rescaler_pkg.sv
// Shared datapath constants and types for the approximate multiplier
// (input shifter, core multiplier and product rescaler).
package product_rescaler_pkg;

   localparam int BITWIDTH        = 8;
   localparam int SHIFTDISTANCE   = 4;
   localparam int OSFM_BITWIDTH_I = BITWIDTH - SHIFTDISTANCE;

   // Count of truncated operands travelling with a product: 0, 1 or 2.
   typedef logic [1:0] nshift_t;

   function automatic int out_prod_width(input int bitwidth);
      return 2 * bitwidth;
   endfunction

endpackage

// File: rtl/product_rescaler_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module product_rescaler_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/product_rescaler.sv
// Restores full 2*BITWIDTH scale of a reduced-width product by shifting it left
// once per truncated operand; 2-stage valid/ready pipeline plus truncation stats.
module product_rescaler #(
   parameter int BITWIDTH      = product_rescaler_pkg::BITWIDTH,
   parameter int SHIFTDISTANCE = product_rescaler_pkg::SHIFTDISTANCE,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [2*(BITWIDTH-SHIFTDISTANCE)-1:0]    in_prod,
   input  logic                                     in_shift_possible_a,
   input  logic                                     in_shift_possible_b,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [2*BITWIDTH-1:0]                    out_prod,
   output logic [CNT_WIDTH-1:0]                     trunc_count,
   output logic [CNT_WIDTH-1:0]                     total_count,
   input  logic                                     clr_stats
);

   import product_rescaler_pkg::*;

   localparam int OSFM_BITWIDTH_I = BITWIDTH - SHIFTDISTANCE;
   localparam int IN_W           = 2 * OSFM_BITWIDTH_I;
   localparam int PROD_W         = out_prod_width(BITWIDTH);

   logic              en;
   logic              accept;
   nshift_t           nshift_in;

   logic              s1_valid_q;
   logic [IN_W-1:0]   s1_prod_q;
   nshift_t           s1_nshift_q;

   logic              out_valid_q;
   logic [PROD_W-1:0] out_prod_q;
   logic [PROD_W-1:0] out_prod_d;

   assign en        = out_ready | ~out_valid_q;
   assign in_ready  = en;
   assign accept    = in_valid & en;
   assign nshift_in = {1'b0, ~in_shift_possible_a} + {1'b0, ~in_shift_possible_b};

   // Max shift (2*SHIFTDISTANCE) plus IN_W is exactly PROD_W, so nothing is lost.
   assign out_prod_d = PROD_W'(s1_prod_q) << (SHIFTDISTANCE * int'(s1_nshift_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_prod_q   <= '0;
         s1_nshift_q <= '0;
         out_valid_q <= 1'b0;
         out_prod_q  <= '0;
      end else if (en) begin
         s1_valid_q  <= in_valid;
         s1_prod_q   <= in_prod;
         s1_nshift_q <= nshift_in;
         out_valid_q <= s1_valid_q;
         out_prod_q  <= out_prod_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_prod  = out_prod_q;

   product_rescaler_sat_counter #(.WIDTH(CNT_WIDTH)) u_total_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_stats),
      .inc_i   (accept),
      .count_o (total_count)
   );

   product_rescaler_sat_counter #(.WIDTH(CNT_WIDTH)) u_trunc_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_stats),
      .inc_i   (accept & (nshift_in != 2'd0)),
      .count_o (trunc_count)
   );

endmodule

// File: tb/tb_product_rescaler.sv
// Directed test of product_rescaler with hand-computed expectations (CNT_WIDTH=4).
module tb_product_rescaler;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_prod;
   logic        in_shift_possible_a;
   logic        in_shift_possible_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_prod;
   logic [3:0]  trunc_count;
   logic [3:0]  total_count;
   logic        clr_stats;

   int vec_cnt = 0;
   int err_cnt = 0;

   product_rescaler #(
      .BITWIDTH      (8),
      .SHIFTDISTANCE (4),
      .CNT_WIDTH     (4)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_prod             (in_prod),
      .in_shift_possible_a (in_shift_possible_a),
      .in_shift_possible_b (in_shift_possible_b),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_prod            (out_prod),
      .trunc_count         (trunc_count),
      .total_count         (total_count),
      .clr_stats           (clr_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] p, input logic a, input logic b);
      in_valid            = v;
      in_prod             = p;
      in_shift_possible_a = a;
      in_shift_possible_b = b;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] p);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      if (v) chk({tag, "_prod"}, 32'(out_prod), 32'(p));
   endtask

   task automatic chk_cnt(input string tag, input logic [3:0] tot, input logic [3:0] tr);
      chk({tag, "_total"}, 32'(total_count), 32'(tot));
      chk({tag, "_trunc"}, 32'(trunc_count), 32'(tr));
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      clr_stats = 1'b0;
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_prod", 32'(out_prod), 32'd0);
      chk_cnt("rst", 4'd0, 4'd0);
      rst = 1'b0;
      step();
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // 1: no truncation
      drive(1'b1, 8'hE1, 1'b1, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      chk("t1_lat1_valid", 32'(out_valid), 32'd0);
      chk_cnt("t1", 4'd1, 4'd0);
      step();
      chk_out("t1", 1'b1, 16'h00E1);

      // 2: A truncated
      drive(1'b1, 8'h2D, 1'b0, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      chk_cnt("t2", 4'd2, 4'd1);
      step();
      chk_out("t2", 1'b1, 16'h02D0);

      // 3: both truncated, then back-to-back stream
      drive(1'b1, 8'hFF, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      chk_cnt("t3", 4'd3, 4'd2);
      step();
      chk_out("t3", 1'b1, 16'hFF00);

      drive(1'b1, 8'h01, 1'b1, 1'b1);
      step();
      drive(1'b1, 8'h02, 1'b0, 1'b1);
      step();
      chk_out("s1", 1'b1, 16'h0001);
      drive(1'b1, 8'h03, 1'b0, 1'b0);
      step();
      chk_out("s2", 1'b1, 16'h0020);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      step();
      chk_out("s3", 1'b1, 16'h0300);
      chk_cnt("s", 4'd6, 4'd4);
      step();
      chk_out("s_drain", 1'b0, 16'h0000);

      // 4: back-pressure with two products in flight
      drive(1'b1, 8'h05, 1'b1, 1'b1);
      step();
      drive(1'b1, 8'h07, 1'b0, 1'b1);
      step();
      chk_out("bp_first", 1'b1, 16'h0005);
      out_ready = 1'b0;
      drive(1'b1, 8'h0F, 1'b0, 1'b0);
      #1;
      chk("bp_in_ready_comb", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk_out("bp_hold", 1'b1, 16'h0005);
      end
      chk_cnt("bp", 4'd8, 4'd5);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      step();
      chk_out("bp_second", 1'b1, 16'h0070);
      step();
      chk_out("bp_drain", 1'b0, 16'h0000);
      chk_cnt("bp_after", 4'd8, 4'd5);

      // 5: reset with two products in flight
      drive(1'b1, 8'h11, 1'b1, 1'b1);
      step();
      drive(1'b1, 8'h12, 1'b1, 1'b1);
      step();
      chk_out("r_pre", 1'b1, 16'h0011);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("r_out_valid", 32'(out_valid), 32'd0);
      chk_cnt("r", 4'd0, 4'd0);
      step();
      chk("r_no_partial", 32'(out_valid), 32'd0);
      drive(1'b1, 8'h33, 1'b1, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      chk_cnt("r_next", 4'd1, 4'd1);
      step();
      chk_out("r_next", 1'b1, 16'h0330);

      // 6: saturation and clear
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      chk_cnt("sat", 4'hF, 4'hF);
      step();
      step();
      chk_cnt("sat_hold", 4'hF, 4'hF);
      drive(1'b1, 8'h44, 1'b1, 1'b1);
      clr_stats = 1'b1;
      step();
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      clr_stats = 1'b0;
      chk_cnt("clr", 4'd0, 4'd0);
      step();
      chk_out("clr_pipe", 1'b1, 16'h0044);
      drive(1'b1, 8'h5A, 1'b1, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      chk_cnt("post_clr", 4'd1, 4'd0);
      step();
      chk_out("post_clr", 1'b1, 16'h005A);

      // invalid cycles must not touch the counters
      drive(1'b0, 8'hAA, 1'b0, 1'b0);
      step();
      step();
      chk_cnt("idle_data", 4'd1, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
